uart_tx_dev: RTL and testbench



---
 rtl/uart_tx_dev_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_dev.sv | 155 +++++++++++++++
 tb/tb_uart_tx_dev.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_dev_pkg.sv
// uart_tx_dev_pkg: register map, FSM encoding and STATUS layout shared by the UART TX peripheral
package uart_tx_dev_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;
    localparam logic [1:0] UART_DIV    = 2'd3;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int CNT_W        = 5;

    localparam int IRQ_VEC_IDX  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO with wrap-bit pointers; push when full and pop when empty are ignored
module uart_tx_fifo
    import uart_tx_dev_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [7:0]       i_din,
    output logic [7:0]       o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] w_diff;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_diff    = r_wr - r_rd;
    assign o_empty   = (w_diff == '0);
    assign o_full    = (w_diff == (AW+1)'(FIFO_DEPTH));
    assign o_count   = CNT_W'(w_diff);
    assign o_dout    = r_mem[r_rd[AW-1:0]];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointer update; full/empty are judged on the pre-cycle occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset: clearing the pointers discards its contents
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with TX FIFO, programmable divisor and drain IRQ
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        txd,
    output logic        IRQ
);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [1:0]       r_ctrl;
    logic [15:0]      r_div;
    logic             r_ovf;
    logic             r_irq;
    logic [7:0]       r_shift;
    logic [15:0]      r_period;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit_idx;

    logic [1:0]       w_addr;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_fifo_dout;
    logic [CNT_W-1:0] w_count;
    logic             w_busy;
    logic             w_bit_end;
    logic             w_start_ok;
    logic [15:0]      w_div_eff;
    logic [31:0]      w_status;
    logic             w_unused;

    assign w_addr     = Addr[1:0];
    assign w_push     = WE && (w_addr == UART_DATA);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_bit_end  = (r_baud == r_period - 16'd1);
    assign w_start_ok = r_ctrl[0] & ~w_empty;
    assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign IRQ        = r_irq;
    assign w_unused   = ^{Addr[29:2], Din[31:16]};

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (Din[7:0]),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // STATUS word assembled from live state
    always_comb begin
        w_status                           = '0;
        w_status[ST_BUSY_BIT]              = w_busy;
        w_status[ST_FULL_BIT]              = w_full;
        w_status[ST_EMPTY_BIT]             = w_empty;
        w_status[ST_OVF_BIT]               = r_ovf;
        w_status[ST_CNT_LSB +: CNT_W]      = w_count;
    end

    assign Dout = (w_addr == UART_STATUS) ? w_status :
                  (w_addr == UART_CTRL)   ? {30'd0, r_ctrl} :
                  (w_addr == UART_DIV)    ? {16'd0, r_div} : 32'd0;

    // CPU-visible registers, sticky overflow and registered drain interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= 2'd0;
            r_div  <= DIV_RESET;
            r_ovf  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_irq <= r_ctrl[1] & w_empty & ~w_busy;
            if (WE) begin
                if (w_addr == UART_DATA && w_full) r_ovf  <= 1'b1;
                if (w_addr == UART_STATUS)         r_ovf  <= 1'b0;
                if (w_addr == UART_CTRL)           r_ctrl <= Din[1:0];
                if (w_addr == UART_DIV)            r_div  <= Din[15:0];
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, FIFO pop and line level; STOP chains straight into START for gapless frames
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        txd         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = w_start_ok ? ST_START : ST_IDLE;
                w_pop       = w_start_ok;
            end
            ST_START: begin
                txd = 1'b0;
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                txd = r_shift[0];
                if (w_bit_end && r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = w_start_ok ? ST_START : ST_IDLE;
                    w_pop       = w_start_ok;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit timing and shifter; the period is latched per frame so DIVISOR edits wait for the next one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= 8'd0;
            r_period  <= 16'd1;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
        end else if (w_pop) begin
            r_shift   <= w_fifo_dout;
            r_period  <= w_div_eff;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
        end else if (w_busy) begin
            if (w_bit_end) begin
                r_baud <= 16'd0;
                if (r_state == ST_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed plus random stimulus checked cycle by cycle against a frame-level model
module tb_uart_tx_dev;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        txd;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mq[$];
    logic [1:0] m_ctrl;
    int         m_div;
    bit         m_ovf;
    bit         m_active;
    int         m_start;
    int         m_period;
    int         cyc;
    bit         m_irq;
    logic [9:0] m_frame;

    uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd16)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .txd   (txd),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = mq.size();
        return 32'(n) * 16 + (m_ovf ? 8 : 0) + (n == 0 ? 4 : 0) + (n == DEPTH ? 2 : 0) + (m_active ? 1 : 0);
    endfunction

    function automatic logic exp_txd();
        if (!m_active) return 1'b1;
        return m_frame[(cyc - m_start) / m_period];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ctrl = 2'd0; m_div = 16; m_ovf = 0; m_active = 0; m_irq = 0;
    endtask

    // One clock edge: advance the model using pre-edge values, then compare line and IRQ
    task automatic tick();
        int  pre_n;
        bit  pre_act, fin;
        @(posedge clk);
        cyc++;
        pre_n   = mq.size();
        pre_act = m_active;
        fin     = m_active && (cyc == m_start + 10 * m_period);
        m_irq   = m_ctrl[1] && pre_n == 0 && !pre_act;
        if ((!pre_act || fin) && m_ctrl[0] && pre_n > 0) begin
            m_frame  = {1'b1, mq.pop_front(), 1'b0};
            m_active = 1;
            m_start  = cyc;
            m_period = (m_div == 0) ? 1 : m_div;
        end else if (fin) begin
            m_active = 0;
        end
        if (WE) begin
            case (Addr[1:0])
                2'd0: if (pre_n == DEPTH) m_ovf = 1; else mq.push_back(Din[7:0]);
                2'd1: m_ovf = 0;
                2'd2: m_ctrl = Din[1:0];
                default: m_div = int'(Din[15:0]);
            endcase
        end
        #1;
        chk("txd", 32'(txd), 32'(exp_txd()));
        chk("irq", 32'(IRQ), 32'(m_irq));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a}; Din = d; WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] expv);
        Addr = {28'd0, a};
        #1;
        chk(tag, Dout, expv);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            rd("status", 2'd1, exp_status());
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(IRQ), 32'd0);
        rd("rst_status", 2'd1, 32'h4);
        tick();
        tick();
        #2 reset = 1'b1;
    endtask

    initial begin
        int r;
        cyc = 0;
        model_reset();
        #12 reset = 1'b1;
        chk("init_txd", 32'(txd), 32'd1);
        chk("init_irq", 32'(IRQ), 32'd0);
        rd("init_status", 2'd1, 32'h4);
        rd("init_div", 2'd3, 32'h10);
        rd("init_ctrl", 2'd2, 32'h0);
        rd("init_data", 2'd0, 32'h0);

        // single 0xA5 frame at divisor 4
        wr(2'd3, 32'd4);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'hA5);
        run(45);
        rd("a5_status", 2'd1, 32'h4);

        // overflow with transmitter disabled, then clear ovf
        wr(2'd2, 32'd0);
        for (int i = 0; i < 9; i++) wr(2'd0, 32'(8'h30 + i));
        rd("ovf_status", 2'd1, 32'h8A);
        wr(2'd1, 32'hFFFF_FFFF);
        rd("ovf_clear", 2'd1, 32'h82);
        wr(2'd3, 32'd1);
        wr(2'd2, 32'd1);
        run(85);

        // three back-to-back frames at divisor 2
        wr(2'd3, 32'd2);
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h5A);
        wr(2'd0, 32'hC3);
        run(64);

        // drain IRQ at divisor 1, then cleared by a new byte
        wr(2'd3, 32'h0);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h96);
        run(14);
        rd("irq_status", 2'd1, 32'h4);
        chk("irq_high", 32'(IRQ), 32'd1);
        wr(2'd0, 32'h3C);
        run(14);

        // reset mid-frame
        wr(2'd3, 32'd4);
        wr(2'd0, 32'h55);
        wr(2'd0, 32'hAA);
        run(15);
        do_reset();
        rd("post_rst_ctrl", 2'd2, 32'h0);
        rd("post_rst_div", 2'd3, 32'h10);
        run(50);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25)      wr(2'd0, $urandom);
            else if (r < 27) wr(2'd1, $urandom);
            else if (r < 33) wr(2'd2, {$urandom_range(0, 65535), 14'd0, 2'($urandom_range(0, 3))});
            else if (r < 37) wr(2'd3, {16'($urandom), 14'd0, 2'($urandom_range(0, 3))});
            else             tick();
            rd("rnd_status", 2'd1, exp_status());
            if (i % 50 == 0) begin
                rd("rnd_ctrl", 2'd2, {30'd0, m_ctrl});
                rd("rnd_div", 2'd3, 32'(m_div));
            end
            if (i == 1500) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
